// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, opcode and datapath-select encodings for the multicycle controller
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'b0001,
    ST_DECODE  = 4'b0101,
    ST_MEMADR  = 4'b0110,
    ST_LBRD    = 4'b0111,
    ST_LBWR    = 4'b1000,
    ST_SBWR    = 4'b1001,
    ST_RTYPEEX = 4'b1010,
    ST_RTYPEWR = 4'b1011,
    ST_BEQEX   = 4'b1100,
    ST_JEX     = 4'b1101,
    ST_ADDIWR  = 4'b1110,
    ST_BNEEX   = 4'b1111
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_J     = 6'b100010;
  localparam logic [5:0] OP_BEQ   = 6'b100100;
  localparam logic [5:0] OP_BNE   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_fetch_seq.sv
// rtl/mc_fetch_seq.sv - fetch-beat counter and one-hot IR byte-lane write decoder
module mc_fetch_seq #(
  parameter int WORD_BYTES = 4,
  parameter int FCNT_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  mem_ready,
  output logic                  last_beat,
  output logic [WORD_BYTES-1:0] irwrite
);

  logic [FCNT_W-1:0] fbyte_q, fbyte_d;
  logic              beat;

  always_comb begin
    beat      = fetch_en & mem_ready;
    last_beat = (fbyte_q == FCNT_W'(WORD_BYTES - 1));
    fbyte_d   = fbyte_q;
    if (beat) begin
      fbyte_d = last_beat ? '0 : fbyte_q + FCNT_W'(1);
    end
    irwrite = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      irwrite[i] = beat && (fbyte_q == FCNT_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbyte_q <= '0;
    end else begin
      fbyte_q <= fbyte_d;
    end
  end

endmodule

// File: rtl/mc_controller_param.sv
// rtl/mc_controller_param.sv - parametrised multicycle MIPS control FSM with wait handshake
module mc_controller_param
  import mc_ctrl_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int FCNT_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            op,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  memread,
  output logic                  memwrite,
  output logic                  iord,
  output logic                  alusrca,
  output logic [1:0]            alusrcb,
  output logic [1:0]            aluop,
  output logic [1:0]            pcsource,
  output logic                  pcen,
  output logic                  regwrite,
  output logic                  regdst,
  output logic                  memtoreg,
  output logic [WORD_BYTES-1:0] irwrite,
  output logic [3:0]            state,
  output logic                  illegal_op,
  output logic                  instr_done
);

  state_t state_q, state_d;

  logic                  last_beat;
  logic [WORD_BYTES-1:0] irwrite_c;
  logic                  pcwrite;
  logic                  memread_c, memwrite_c, iord_c, alusrca_c;
  logic [1:0]            alusrcb_c, aluop_c, pcsource_c;
  logic                  pcen_c, regwrite_c, regdst_c, memtoreg_c;
  logic                  illegal_c, done_c;

  mc_fetch_seq #(
    .WORD_BYTES (WORD_BYTES),
    .FCNT_W     (FCNT_W)
  ) u_fetch_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (state_q == ST_FETCH),
    .mem_ready (mem_ready),
    .last_beat (last_beat),
    .irwrite   (irwrite_c)
  );

  always_comb begin
    state_d    = state_q;
    pcwrite    = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    iord_c     = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = SRCB_B;
    aluop_c    = ALUOP_ADD;
    pcsource_c = PCSRC_ALU;
    regwrite_c = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    illegal_c  = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = SRCB_ONE;
        pcwrite   = mem_ready;
        if (mem_ready && last_beat) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alusrcb_c = SRCB_BOFF;
        case (op)
          OP_LB, OP_SB, OP_ADDI: state_d = ST_MEMADR;
          OP_RTYPE:              state_d = ST_RTYPEEX;
          OP_BEQ:                state_d = ST_BEQEX;
          OP_BNE:                state_d = ST_BNEEX;
          OP_J:                  state_d = ST_JEX;
          default: begin
            state_d   = ST_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = SRCB_IMM;
        case (op)
          OP_LB:   state_d = ST_LBRD;
          OP_SB:   state_d = ST_SBWR;
          OP_ADDI: state_d = ST_ADDIWR;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_LBRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) state_d = ST_LBWR;
      end
      ST_LBWR: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        done_c     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_SBWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        done_c     = mem_ready;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_RTYPEEX: begin
        alusrca_c = 1'b1;
        aluop_c   = ALUOP_FUNCT;
        state_d   = ST_RTYPEWR;
      end
      ST_RTYPEWR: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
        done_c     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_ADDIWR: begin
        regwrite_c = 1'b1;
        done_c     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BEQEX, ST_BNEEX: begin
        alusrca_c  = 1'b1;
        aluop_c    = ALUOP_SUB;
        pcsource_c = PCSRC_ALUOUT;
        done_c     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_JEX: begin
        pcwrite    = 1'b1;
        pcsource_c = PCSRC_JUMP;
        done_c     = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    pcen_c = pcwrite | ((state_q == ST_BEQEX) & zero) | ((state_q == ST_BNEEX) & ~zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset must silence the datapath immediately, not just at the next edge.
  assign memread    = rst_n & memread_c;
  assign memwrite   = rst_n & memwrite_c;
  assign iord       = rst_n & iord_c;
  assign alusrca    = rst_n & alusrca_c;
  assign alusrcb    = {2{rst_n}} & alusrcb_c;
  assign aluop      = {2{rst_n}} & aluop_c;
  assign pcsource   = {2{rst_n}} & pcsource_c;
  assign pcen       = rst_n & pcen_c;
  assign regwrite   = rst_n & regwrite_c;
  assign regdst     = rst_n & regdst_c;
  assign memtoreg   = rst_n & memtoreg_c;
  assign irwrite    = rst_n ? irwrite_c : '0;
  assign illegal_op = rst_n & illegal_c;
  assign instr_done = rst_n & done_c;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_controller_param.sv
// tb/tb_mc_controller_param.sv - scoreboard bench for mc_controller_param at WORD_BYTES 4 and 2
module tb_mc_controller_param;

  localparam int S_ST = 0, S_IRW = 1, S_PCEN = 2, S_PCSRC = 3, S_REGW = 4, S_REGDST = 5;
  localparam int S_M2R = 6, S_MRD = 7, S_MWR = 8, S_IORD = 9, S_ILL = 10, S_DONE = 11;
  localparam int S_SRCB = 12, S_AOP = 13, S_SRCA = 14;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] op;
  logic zero, mr4, mr2;

  logic memread4, memwrite4, iord4, alusrca4, pcen4, regwrite4, regdst4, memtoreg4, ill4, done4;
  logic [1:0] alusrcb4, aluop4, pcsource4;
  logic [3:0] irwrite4, state4;
  logic memread2, memwrite2, iord2, alusrca2, pcen2, regwrite2, regdst2, memtoreg2, ill2, done2;
  logic [1:0] alusrcb2, aluop2, pcsource2, irwrite2;
  logic [3:0] state2;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cur = 4;

  int st_t[11]  = '{1, 1, 1, 1, 1, 5, 6, 7, 7, 7, 8};
  int irw_t[11] = '{1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
  int mr_t[11]  = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1};

  always #5 clk = ~clk;

  mc_controller_param #(.WORD_BYTES(4), .FCNT_W(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mr4),
    .memread(memread4), .memwrite(memwrite4), .iord(iord4), .alusrca(alusrca4),
    .alusrcb(alusrcb4), .aluop(aluop4), .pcsource(pcsource4), .pcen(pcen4),
    .regwrite(regwrite4), .regdst(regdst4), .memtoreg(memtoreg4), .irwrite(irwrite4),
    .state(state4), .illegal_op(ill4), .instr_done(done4)
  );

  mc_controller_param #(.WORD_BYTES(2), .FCNT_W(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mr2),
    .memread(memread2), .memwrite(memwrite2), .iord(iord2), .alusrca(alusrca2),
    .alusrcb(alusrcb2), .aluop(aluop2), .pcsource(pcsource2), .pcen(pcen2),
    .regwrite(regwrite2), .regdst(regdst2), .memtoreg(memtoreg2), .irwrite(irwrite2),
    .state(state2), .illegal_op(ill2), .instr_done(done2)
  );

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_ST:     return (cur == 4) ? 8'(state4)    : 8'(state2);
      S_IRW:    return (cur == 4) ? 8'(irwrite4)  : 8'(irwrite2);
      S_PCEN:   return (cur == 4) ? 8'(pcen4)     : 8'(pcen2);
      S_PCSRC:  return (cur == 4) ? 8'(pcsource4) : 8'(pcsource2);
      S_REGW:   return (cur == 4) ? 8'(regwrite4) : 8'(regwrite2);
      S_REGDST: return (cur == 4) ? 8'(regdst4)   : 8'(regdst2);
      S_M2R:    return (cur == 4) ? 8'(memtoreg4) : 8'(memtoreg2);
      S_MRD:    return (cur == 4) ? 8'(memread4)  : 8'(memread2);
      S_MWR:    return (cur == 4) ? 8'(memwrite4) : 8'(memwrite2);
      S_IORD:   return (cur == 4) ? 8'(iord4)     : 8'(iord2);
      S_ILL:    return (cur == 4) ? 8'(ill4)      : 8'(ill2);
      S_DONE:   return (cur == 4) ? 8'(done4)     : 8'(done2);
      S_SRCB:   return (cur == 4) ? 8'(alusrcb4)  : 8'(alusrcb2);
      S_AOP:    return (cur == 4) ? 8'(aluop4)    : 8'(aluop2);
      S_SRCA:   return (cur == 4) ? 8'(alusrca4)  : 8'(alusrca2);
      default:  return 8'hff;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s (dut%0d): got %0h expected %0h", tag, cur, got, want);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    push("rst_state", S_ST, 8'h1);
    push("rst_irw", S_IRW, 8'h0);
    push("rst_pcen", S_PCEN, 8'h0);
    push("rst_memread", S_MRD, 8'h0);
    push("rst_srcb", S_SRCB, 8'h0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fetch_all(input int n);
    for (int i = 0; i < n; i++) begin
      push("fetch_state", S_ST, 8'h1);
      push("fetch_irw", S_IRW, 8'(1 << i));
      push("fetch_pcen", S_PCEN, 8'h1);
      push("fetch_memread", S_MRD, 8'h1);
      push("fetch_srcb", S_SRCB, 8'h1);
      push("fetch_done", S_DONE, 8'h0);
      cyc();
    end
  endtask

  task automatic decode_legal();
    push("dec_state", S_ST, 8'h5);
    push("dec_srcb", S_SRCB, 8'h3);
    push("dec_ill", S_ILL, 8'h0);
    cyc();
  endtask

  task automatic memadr();
    push("madr_state", S_ST, 8'h6);
    push("madr_srca", S_SRCA, 8'h1);
    push("madr_srcb", S_SRCB, 8'h2);
    cyc();
  endtask

  task automatic branch(input logic [5:0] opv, input logic z, input logic [7:0] st, input logic [7:0] pc);
    op = opv;
    zero = z;
    do_reset();
    fetch_all(4);
    decode_legal();
    push("br_state", S_ST, st);
    push("br_pcen", S_PCEN, pc);
    push("br_pcsrc", S_PCSRC, 8'h1);
    push("br_aluop", S_AOP, 8'h1);
    push("br_done", S_DONE, 8'h1);
    cyc();
    push("br_next", S_ST, 8'h1);
    cyc();
  endtask

  initial begin
    rst_n = 1'b1;
    op = 6'b000000;
    zero = 1'b0;
    mr4 = 1'b1;
    mr2 = 1'b1;
    #2;
    do_reset();

    // R-type, zero-wait: RTYPEWR lands on cycle 7
    fetch_all(4);
    decode_legal();
    push("rex_state", S_ST, 8'ha);
    push("rex_aluop", S_AOP, 8'h2);
    push("rex_srca", S_SRCA, 8'h1);
    cyc();
    push("rwr_state", S_ST, 8'hb);
    push("rwr_regw", S_REGW, 8'h1);
    push("rwr_regdst", S_REGDST, 8'h1);
    push("rwr_done", S_DONE, 8'h1);
    cyc();

    // Reset asserted while LBRD waits on memory
    op = 6'b100000;
    do_reset();
    fetch_all(4);
    decode_legal();
    memadr();
    mr4 = 1'b0;
    push("lbrd_state", S_ST, 8'h7);
    push("lbrd_memread", S_MRD, 8'h1);
    push("lbrd_iord", S_IORD, 8'h1);
    cyc();
    rst_n = 1'b0;
    #1;
    push("midrst_state", S_ST, 8'h1);
    push("midrst_memread", S_MRD, 8'h0);
    push("midrst_iord", S_IORD, 8'h0);
    push("midrst_regw", S_REGW, 8'h0);
    push("midrst_irw", S_IRW, 8'h0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mr4 = 1'b1;
    push("post_rst_irw", S_IRW, 8'h1);
    push("post_rst_pcen", S_PCEN, 8'h1);
    cyc();

    // WORD_BYTES=2 LB with wait states: 11 cycles total
    cur = 2;
    op = 6'b100000;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      mr2 = mr_t[i][0];
      push("lb2_state", S_ST, 8'(st_t[i]));
      push("lb2_irw", S_IRW, 8'(irw_t[i]));
      if (i < 5) push("lb2_pcen", S_PCEN, 8'(irw_t[i] != 0));
      push("lb2_done", S_DONE, 8'(i == 10));
      if (i == 10) begin
        push("lb2_memtoreg", S_M2R, 8'h1);
        push("lb2_regw", S_REGW, 8'h1);
      end
      cyc();
    end
    mr2 = 1'b1;
    push("lb2_next", S_ST, 8'h1);
    cyc();
    cur = 4;

    branch(6'b100100, 1'b1, 8'hc, 8'h1);
    branch(6'b100100, 1'b0, 8'hc, 8'h0);
    branch(6'b100101, 1'b1, 8'hf, 8'h0);
    branch(6'b100101, 1'b0, 8'hf, 8'h1);

    op = 6'b001000;
    do_reset();
    fetch_all(4);
    decode_legal();
    memadr();
    push("addi_state", S_ST, 8'he);
    push("addi_regw", S_REGW, 8'h1);
    push("addi_regdst", S_REGDST, 8'h0);
    push("addi_memtoreg", S_M2R, 8'h0);
    push("addi_done", S_DONE, 8'h1);
    cyc();

    op = 6'b100010;
    do_reset();
    fetch_all(4);
    decode_legal();
    push("j_state", S_ST, 8'hd);
    push("j_pcen", S_PCEN, 8'h1);
    push("j_pcsrc", S_PCSRC, 8'h2);
    push("j_done", S_DONE, 8'h1);
    cyc();

    op = 6'b101000;
    do_reset();
    fetch_all(4);
    decode_legal();
    memadr();
    push("sb_state", S_ST, 8'h9);
    push("sb_memwrite", S_MWR, 8'h1);
    push("sb_iord", S_IORD, 8'h1);
    push("sb_done", S_DONE, 8'h1);
    cyc();

    op = 6'b111111;
    do_reset();
    fetch_all(4);
    push("ill_state", S_ST, 8'h5);
    push("ill_flag", S_ILL, 8'h1);
    push("ill_done", S_DONE, 8'h0);
    cyc();
    push("ill_next_state", S_ST, 8'h1);
    push("ill_flag_clear", S_ILL, 8'h0);
    push("ill_regw", S_REGW, 8'h0);
    push("ill_memwrite", S_MWR, 8'h0);
    push("ill_next_irw", S_IRW, 8'h1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
